// File: rtl/twos_to_signmag_pkg.sv
// Shared constants and state encoding for the serial two's-complement to
// sign-magnitude converter.
package twos_to_signmag_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_neg_cell.sv
// One-bit serial negation cell: passes bits through up to and including the
// first 1 seen (LSB first), then inverts the rest when the operand is negative.
module serial_neg_cell (
   input  logic b,
   input  logic sign,
   input  logic seen_one,
   output logic out_bit_c,
   output logic seen_one_c
);

   always_comb begin
      out_bit_c  = (sign & seen_one) ? ~b : b;
      seen_one_c = seen_one | b;
   end

endmodule

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready
// handshakes on both sides and a fixed WIDTH+1 cycle compute latency.
module twos_to_signmag
   import twos_to_signmag_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [WIDTH-1:0] mag,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               seen_q, seen_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic               in_hs;
   logic               last_cnt;
   logic               out_bit;
   logic               seen_nxt;

   assign in_hs    = in_valid & in_ready_q;
   assign last_cnt = (cnt_q == CNT_W'(WIDTH));

   serial_neg_cell u_cell (
      .b          (shreg_q[0]),
      .sign       (neg_q),
      .seen_one   (seen_q),
      .out_bit_c  (out_bit),
      .seen_one_c (seen_nxt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the extra SHIFT cycle at cnt == WIDTH commits the result
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_hs)     state_d = SHIFT;
         SHIFT:   if (last_cnt)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      acc_d       = acc_q;
      neg_d       = neg_q;
      seen_d      = seen_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (in_hs) begin
               shreg_d = x;
               neg_d   = x[WIDTH-1];
               seen_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (last_cnt) begin
               sign_d = neg_q;
               mag_d  = acc_q;
            end else begin
               shreg_d = shreg_q >> 1;
               acc_d   = {out_bit, acc_q[WIDTH-1:1]};
               seen_d  = seen_nxt;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         shreg_q     <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         seen_q      <= 1'b0;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         acc_q       <= acc_d;
         neg_q       <= neg_d;
         seen_q      <= seen_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sign      = sign_q;
   assign mag       = mag_q;
   assign busy      = busy_q;

endmodule
